// File: rtl/dm_load_unit.sv
// Load unit: issues a word read to a fixed-latency synchronous data memory and returns the
// sign/zero-extended field to W. Define MISALIGN_EXC_EN to trap misaligned loads via adel.
module dm_load_unit #(
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req,
   input  logic [2:0]        ld_type,
   input  logic [31:0]       addr,
   input  logic              flush,
   output logic              busy,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       rdata,
   output logic              valid,
   output logic              adel
);

   localparam logic [2:0] LT_LH  = 3'd1;
   localparam logic [2:0] LT_LHU = 3'd2;
   localparam logic [2:0] LT_LB  = 3'd3;
   localparam logic [2:0] LT_LBU = 3'd4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        type_q, type_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              unused_addr;

   assign unused_addr = ^addr[31:ADDR_W+2];

   // Codes 5..7 fall into the default arm and behave as lw.
   function automatic logic [31:0] extend(input logic [2:0] t, input logic [1:0] off,
                                          input logic [31:0] w);
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] r;
      h = off[1] ? w[31:16] : w[15:0];
      b = w[{off, 3'b000} +: 8];
      case (t)
         LT_LH:   r = {{16{h[15]}}, h};
         LT_LHU:  r = {16'h0000, h};
         LT_LB:   r = {{24{b[7]}}, b};
         LT_LBU:  r = {24'h000000, b};
         default: r = w;
      endcase
      return r;
   endfunction

`ifdef MISALIGN_EXC_EN
   logic adel_q, adel_d;
   logic misaligned;

   always_comb begin
      case (ld_type)
         LT_LH, LT_LHU: misaligned = addr[0];
         LT_LB, LT_LBU: misaligned = 1'b0;
         default:       misaligned = (addr[1:0] != 2'b00);
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      off_d   = off_q;
      maddr_d = maddr_q;
      rdata_d = rdata_q;
      valid_d = 1'b0;
`ifdef MISALIGN_EXC_EN
      adel_d  = 1'b0;
`endif
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  type_d  = ld_type;
                  off_d   = addr[1:0];
                  maddr_d = addr[ADDR_W+1:2];
                  state_d = ISSUE;
`ifdef MISALIGN_EXC_EN
                  // Trapped loads never touch memory; the exception is reported next cycle.
                  if (misaligned) begin
                     state_d = IDLE;
                     valid_d = 1'b1;
                     adel_d  = 1'b1;
                     rdata_d = '0;
                  end
`endif
               end
            end
            ISSUE: begin
               state_d = WAIT;
               cnt_d   = 3'(RD_LAT);
            end
            WAIT: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = IDLE;
                  rdata_d = extend(type_q, off_q, mem_rdata);
                  valid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         type_q  <= '0;
         off_q   <= '0;
         maddr_q <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         off_q   <= off_d;
         maddr_q <= maddr_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
      end
   end

`ifdef MISALIGN_EXC_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) adel_q <= 1'b0;
      else      adel_q <= adel_d;
   end
   assign adel = adel_q;
`else
   assign adel = 1'b0;
`endif

   assign busy      = (state_q != IDLE);
   assign mem_rd_en = (state_q == ISSUE) && !flush;
   assign mem_addr  = maddr_q;
   assign rdata     = rdata_q;
   assign valid     = valid_q;

endmodule
